// File: rtl/operand_stage.sv
// Operand stage: single-entry pipeline register between decode and the ALU.
// Resolves rs1/rs2 through the EX/MEM/WB bypass network at capture time,
// selects ALU operands, and stalls one cycle on a load-use dependency.

package operand_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module operand_stage
  import operand_pkg::*;
#(
  parameter bit FORWARD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_op_t     in_alu_op,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  word_t       in_rs1_data,
  input  word_t       in_rs2_data,
  input  word_t       in_imm,
  input  word_t       in_pc,
  input  logic [1:0]  in_op1_sel,
  input  logic        in_op2_sel,
  input  logic        in_rs2_used,
  input  logic        in_rd_wen,
  input  logic        in_is_load,
  input  logic        flush,
  input  word_t       alu_out,
  input  logic [4:0]  mem_rd,
  input  logic        mem_wen,
  input  word_t       mem_data,
  input  logic [4:0]  wb_rd,
  input  logic        wb_wen,
  input  word_t       wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output alu_op_t     out_alu_op,
  output word_t       out_op1,
  output word_t       out_op2,
  output word_t       out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_is_load
);

  // Held entry (stage p1)
  logic       vld_p1;
  alu_op_t    op_p1;
  word_t      op1_p1;
  word_t      op2_p1;
  word_t      sd_p1;
  logic [4:0] rd_p1;
  logic       wen_p1;
  logic       ld_p1;

  logic       hazard;
  logic       cap;
  logic       rs1_dep;
  logic       rs2_dep;
  word_t      rs1_res;
  word_t      rs2_res;
  word_t      op1_nxt;
  word_t      op2_nxt;

  // Bypass priority: x0, held ALU result (non-load), MEM, WB, register file.
  function automatic word_t resolve(
    input logic [4:0] rs,
    input word_t      rf_data,
    input logic       held_vld,
    input logic       held_wen,
    input logic [4:0] held_rd,
    input logic       held_ld,
    input word_t      held_alu,
    input logic       m_wen,
    input logic [4:0] m_rd,
    input word_t      m_data,
    input logic       w_wen,
    input logic [4:0] w_rd,
    input word_t      w_data
  );
    word_t r;
    if (rs == 5'd0)
      r = '0;
    else if (held_vld && held_wen && (held_rd == rs) && !held_ld)
      r = held_alu;
    else if (m_wen && (m_rd == rs))
      r = m_data;
    else if (w_wen && (w_rd == rs))
      r = w_data;
    else
      r = rf_data;
    return r;
  endfunction

  // Load-use detection against the held entry, plus operand resolution and muxing
  always_comb begin
    rs1_dep = (rd_p1 == in_rs1) && (in_op1_sel == 2'b00);
    rs2_dep = (rd_p1 == in_rs2) && (!in_op2_sel || in_rs2_used);
    hazard  = FORWARD && vld_p1 && ld_p1 && wen_p1 && (rd_p1 != 5'd0) &&
              (rs1_dep || rs2_dep);

    if (FORWARD) begin
      rs1_res = resolve(in_rs1, in_rs1_data, vld_p1, wen_p1, rd_p1, ld_p1, alu_out,
                        mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
      rs2_res = resolve(in_rs2, in_rs2_data, vld_p1, wen_p1, rd_p1, ld_p1, alu_out,
                        mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
    end else begin
      rs1_res = in_rs1_data;
      rs2_res = in_rs2_data;
    end

    unique case (in_op1_sel)
      2'b00:   op1_nxt = rs1_res;
      2'b01:   op1_nxt = in_pc;
      default: op1_nxt = '0;  // 10 is zero; reserved 11 also yields zero
    endcase

    op2_nxt = in_op2_sel ? in_imm : rs2_res;
  end

  assign in_ready = !reset && !flush && !hazard && (!vld_p1 || out_ready);
  assign cap      = in_valid && in_ready;

  // Stage p0 -> p1: capture on handshake, drain on accept, kill on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      op_p1  <= ALU_ADD;
      op1_p1 <= '0;
      op2_p1 <= '0;
      sd_p1  <= '0;
      rd_p1  <= '0;
      wen_p1 <= 1'b0;
      ld_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (cap) begin
      vld_p1 <= 1'b1;
      op_p1  <= in_alu_op;
      op1_p1 <= op1_nxt;
      op2_p1 <= op2_nxt;
      sd_p1  <= rs2_res;
      rd_p1  <= in_rd;
      wen_p1 <= in_rd_wen;
      ld_p1  <= in_is_load;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid      = vld_p1;
  assign out_alu_op     = op_p1;
  assign out_op1        = op1_p1;
  assign out_op2        = op2_p1;
  assign out_store_data = sd_p1;
  assign out_rd         = rd_p1;
  assign out_rd_wen     = wen_p1;
  assign out_is_load    = ld_p1;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with an expected-result queue.

module tb_operand_stage;
  import operand_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  alu_op_t    in_alu_op;
  logic [4:0] in_rs1, in_rs2, in_rd;
  word_t      in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [1:0] in_op1_sel;
  logic       in_op2_sel, in_rs2_used, in_rd_wen, in_is_load;
  logic       flush;
  word_t      alu_out;
  logic [4:0] mem_rd, wb_rd;
  logic       mem_wen, wb_wen;
  word_t      mem_data, wb_data;
  logic       out_valid, out_ready;
  alu_op_t    out_alu_op;
  word_t      out_op1, out_op2, out_store_data;
  logic [4:0] out_rd;
  logic       out_rd_wen, out_is_load;

  typedef struct packed {
    alu_op_t    op;
    word_t      op1;
    word_t      op2;
    word_t      sd;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
  } exp_t;

  exp_t sb[$];
  exp_t none;
  int   nvec = 0;
  int   nerr = 0;

  operand_stage #(.FORWARD(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_rs2_used(in_rs2_used), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .flush(flush), .alu_out(alu_out),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op),
    .out_op1(out_op1), .out_op2(out_op2), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input alu_op_t op, input word_t op1, input word_t op2,
                              input word_t sd, input logic [4:0] rd,
                              input logic wen, input logic ld);
    exp_t e;
    e.op = op; e.op1 = op1; e.op2 = op2; e.sd = sd; e.rd = rd; e.wen = wen; e.ld = ld;
    return e;
  endfunction

  task automatic instr(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input word_t d1, input word_t d2,
                       input word_t imm, input word_t pc, input logic [1:0] s1,
                       input logic s2, input logic wen, input logic ld);
    in_valid    = 1'b1;
    in_alu_op   = op;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = imm;
    in_pc       = pc;
    in_op1_sel  = s1;
    in_op2_sel  = s2;
    in_rs2_used = 1'b0;
    in_rd_wen   = wen;
    in_is_load  = ld;
  endtask

  task automatic bypass(input logic mw, input logic [4:0] mr, input word_t md,
                        input logic ww, input logic [4:0] wr, input word_t wd);
    mem_wen = mw; mem_rd = mr; mem_data = md;
    wb_wen  = ww; wb_rd  = wr; wb_data  = wd;
  endtask

  // Push the expectation if this cycle hands off, advance one edge, pop on output.
  task automatic tick(input exp_t e);
    logic cap;
    exp_t x;
    #1;
    cap = in_valid && in_ready;
    if (cap) sb.push_back(e);
    @(posedge clk);
    #1;
    if (cap) begin
      x = sb.pop_front();
      chk("cap_valid", 32'(out_valid),      32'd1);
      chk("cap_op",    32'(out_alu_op),     32'(x.op));
      chk("cap_op1",   out_op1,             x.op1);
      chk("cap_op2",   out_op2,             x.op2);
      chk("cap_sd",    out_store_data,      x.sd);
      chk("cap_rd",    32'(out_rd),         32'(x.rd));
      chk("cap_wen",   32'(out_rd_wen),     32'(x.wen));
      chk("cap_ld",    32'(out_is_load),    32'(x.ld));
    end
  endtask

  initial begin
    none      = '0;
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    alu_out   = '0;
    bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    instr(ALU_SUB, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;

    // Reset state and in_ready held low during reset
    #1 reset = 1'b1;
    in_valid = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid),   32'd0);
    chk("rst_ready", 32'(in_ready),    32'd0);
    chk("rst_op",    32'(out_alu_op),  32'(ALU_ADD));
    chk("rst_op1",   out_op1,          32'd0);
    chk("rst_op2",   out_op2,          32'd0);
    chk("rst_sd",    out_store_data,   32'd0);
    chk("rst_rd",    32'(out_rd),      32'd0);
    chk("rst_wen",   32'(out_rd_wen),  32'd0);
    chk("rst_ld",    32'(out_is_load), 32'd0);
    @(posedge clk); #1;
    chk("rst_edge_valid", 32'(out_valid), 32'd0);
    chk("rst_edge_ready", 32'(in_ready),  32'd0);
    #3 reset = 1'b0;

    // ADD x3,x1,x2 with no bypass hits
    instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 chk("add_ready", 32'(in_ready), 32'd1);
    tick(mk(ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0));

    // Back-to-back: held ALU result beats MEM bypass and stale register data
    alu_out = 32'd12;
    bypass(1'b1, 5'd3, 32'd44, 1'b0, 5'd0, '0);
    instr(ALU_SUB, 5'd3, 5'd5, 5'd6, 32'd99, 32'd1, 32'd100, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    tick(mk(ALU_SUB, 32'd12, 32'd100, 32'd1, 5'd6, 1'b1, 1'b0));

    // MEM beats WB for the same register
    bypass(1'b1, 5'd3, 32'd44, 1'b1, 5'd3, 32'd55);
    instr(ALU_SLL, 5'd3, 5'd8, 5'd0, 32'd99, 32'd8, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(mk(ALU_SLL, 32'd44, 32'd8, 32'd8, 5'd0, 1'b0, 1'b0));

    // PC operand, WB bypass on rs2
    bypass(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h77);
    instr(ALU_AND, 5'd1, 5'd7, 5'd9, 32'd1, 32'd2, '0, 32'h1000, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(mk(ALU_AND, 32'h1000, 32'h77, 32'h77, 5'd9, 1'b1, 1'b0));

    // x0 suppression on rs1, held forward on rs2
    alu_out = 32'hABC;
    bypass(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    instr(ALU_OR, 5'd0, 5'd9, 5'd10, 32'h123, 32'h5, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(mk(ALU_OR, 32'd0, 32'hABC, 32'hABC, 5'd10, 1'b1, 1'b0));

    // LW x4 with reserved op1 select (yields zero) and immediate op2
    bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    instr(ALU_ADD, 5'd1, 5'd0, 5'd4, 32'h5, 32'h6, 32'hFFFFFFFF, '0, 2'b11, 1'b1, 1'b1, 1'b1);
    tick(mk(ALU_ADD, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd4, 1'b1, 1'b1));

    // Load-use: one stall, one bubble, then capture with MEM data
    instr(ALU_XOR, 5'd2, 5'd4, 5'd11, 32'd2, 32'h444, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall_ready", 32'(in_ready), 32'd0);
    tick(none);
    chk("lu_bubble_valid", 32'(out_valid), 32'd0);
    bypass(1'b1, 5'd4, 32'h4000, 1'b0, 5'd0, '0);
    #1 chk("lu_ready", 32'(in_ready), 32'd1);
    tick(mk(ALU_XOR, 32'd2, 32'h4000, 32'h4000, 5'd11, 1'b1, 1'b0));

    // Backpressure: held entry stable, never re-resolved
    out_ready = 1'b0;
    alu_out   = 32'hFFFF;
    bypass(1'b1, 5'd4, 32'h9999, 1'b1, 5'd2, 32'h8888);
    instr(ALU_SRA, 5'd11, 5'd4, 5'd12, 32'd1, 32'd1, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_op1",   out_op1,        32'd2);
      chk("bp_op2",   out_op2,        32'h4000);
      chk("bp_rd",    32'(out_rd),    32'd11);
    end

    // Flush with in_valid high: nothing captured, entry killed
    flush = 1'b1;
    #1 chk("fl_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_sb_empty", 32'(sb.size()), 32'd0);
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reload an entry, then assert reset asynchronously mid-cycle
    bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    instr(ALU_SLT, 5'd5, 5'd6, 5'd12, 32'h50, 32'h60, '0, '0, 2'b10, 1'b0, 1'b1, 1'b0);
    tick(mk(ALU_SLT, 32'd0, 32'h60, 32'h60, 5'd12, 1'b1, 1'b0));
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid),  32'd0);
    chk("ar_ready", 32'(in_ready),   32'd0);
    chk("ar_rd",    32'(out_rd),     32'd0);
    chk("ar_op2",   out_op2,         32'd0);
    @(posedge clk); #1;
    chk("ar_edge_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // First capture after reset release, then drain
    instr(ALU_ADD, 5'd1, 5'd2, 5'd13, 32'd1, 32'd2, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 chk("post_ready", 32'(in_ready), 32'd1);
    tick(mk(ALU_ADD, 32'd1, 32'd2, 32'd2, 5'd13, 1'b1, 1'b0));
    in_valid = 1'b0;
    tick(none);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("sb_empty",    32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter: FORWARD, 1, when 1 enables EX/MEM/WB bypass; when 0 operands come from in_rs*_data only and no load-use stall is raised.
REQ-002 Ports, in this order:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- in_valid in 1 / in_ready out 1: decode-side handshake.
- in_alu_op in alu_op_t.
- in_rs1, in_rs2, in_rd in 5 each: register indices.
- in_rs1_data, in_rs2_data, in_imm, in_pc in word_t.
- in_op1_sel in 2: 00 rs1, 01 pc, 10 zero, 11 reserved.
- in_op2_sel in 1: 0 rs2, 1 imm.
- in_rs2_used in 1.
- in_rd_wen in 1.
- in_is_load in 1.
- flush in 1: kill.
- alu_out in word_t: ALU result of the held entry.
- mem_rd in 5, mem_wen in 1, mem_data in word_t: MEM-stage bypass.
- wb_rd in 5, wb_wen in 1, wb_data in word_t: WB-stage bypass.
- out_valid out 1 / out_ready in 1: ALU-side handshake.
- out_alu_op out alu_op_t.
- out_op1, out_op2, out_store_data out word_t.
- out_rd out 5, out_rd_wen out 1, out_is_load out 1.

Function
REQ-003 Single-entry pipeline register; all out_* are registered, with no combinational path from in_* to out_*.
REQ-004 Capture occurs on a rising edge when in_valid && in_ready; out_valid=1 the next cycle.
REQ-005 in_ready = !flush && !hazard && (!out_valid || out_ready), combinational.
REQ-006 When out_valid && out_ready and no capture occurs, out_valid=0 the next cycle; payload holds its value.
REQ-007 When out_valid && !out_ready, all out_* hold their values.
REQ-008 Operand resolution at capture, per source rsN (N=1,2), in priority order:
- rsN==0: value 0.
- Held entry valid, out_rd_wen, out_rd==rsN, !out_is_load: alu_out.
- mem_wen && mem_rd==rsN: mem_data.
- wb_wen && wb_rd==rsN: wb_data.
- Otherwise: in_rsN_data.
REQ-009 out_op1: resolved rs1 (sel 00), in_pc (01), 0 (10); sel 11 captures 0.
REQ-010 out_op2: resolved rs2 (sel 0) or in_imm (sel 1).
REQ-011 out_store_data = resolved rs2, regardless of in_op2_sel.
REQ-012 Hazard condition:
- out_valid && out_is_load && out_rd_wen && out_rd!=0, and
- either (out_rd==in_rs1 && in_op1_sel==00) or (out_rd==in_rs2 && (in_op2_sel==0 || in_rs2_used)).
- Effect: in_ready=0; if out_ready, a bubble (out_valid=0) follows.
REQ-013 A hazard stalls exactly one cycle per load once the load leaves; the consumer then takes mem_data via REQ-008.
REQ-014 flush=1: out_valid=0 the next cycle, no capture, in_ready=0; flush wins over in_valid, out_ready and hazard.
REQ-015 Forwarding applies only on the capture edge; held operands are never re-resolved.
REQ-016 Throughput: one instruction per cycle when out_ready=1 and there is no hazard or flush.

Reset
REQ-017 When reset is asserted: out_valid=0, out_alu_op=ALU_ADD, out_op1=out_op2=out_store_data=0, out_rd=0, out_rd_wen=0, out_is_load=0, immediately and independent of clk.
REQ-018 in_ready=0 while reset is high; the first capture is on the first edge after deassertion.
REQ-019 Reset mid-stall discards the held entry; no partial state survives.

Verification
REQ-020 ADD x3,x1,x2: in_rs1_data=5, in_rs2_data=7, sel 00/0, no bypass hits -> next cycle out_valid=1, out_op1=5, out_op2=7, out_rd=3.
REQ-021 Back-to-back:
- Held entry rd=3, alu_out=12; next instruction rs1=3, in_rs1_data=99.
- Required: out_op1=12; mem_wen with mem_rd=3, mem_data=44 does not override.
REQ-022 Load-use:
- Held entry LW x4 (out_is_load=1); incoming rs2=4, sel 0.
- Required: in_ready=0 for one cycle, then a bubble, then capture with out_op2 = mem_data while mem_rd=4, mem_wen=1.
REQ-023 x0 suppression: rs1=0 while mem_rd=0, mem_wen=1, mem_data=0xDEADBEEF -> out_op1=0.
REQ-024 Backpressure and flush:
- out_ready=0 for 3 cycles: out_* stable, in_ready=0.
- Then flush=1 with in_valid=1: out_valid=0 the next cycle, nothing captured.
REQ-025 Reset asserted asynchronously mid-cycle while out_valid=1: out_valid drops before the next clk edge; in_ready=0 until deassertion.
